// File: rtl/dmem_mmio_if.sv
// CPU data-side bus: store strobe, byte address, store data and load data.
interface dmem_mmio_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    // CPU side drives the request and receives the load data.
    modport master (output we, output addr, output wd, input rd);
    // Memory side receives the request and returns the load data.
    modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory responder: word RAM plus an LED register and a down-counting
// timer (auto-reload, sticky expiry flag, interrupt) in a small MMIO window.
// Loads are combinational; stores and timer updates happen on the rising edge.
module dmem_mmio #(
    parameter int DM_WORDS = 1024,   // DM_WORDS*4 must stay below 0x7F00
    parameter int LED_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_mmio_if.slave       bus,
    output logic [LED_W-1:0] led,
    output logic             irq
);
    localparam int AW = $clog2(DM_WORDS);

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] W_LED    = 30'h1FC0;
    localparam logic [29:0] W_CTRL   = 30'h1FC1;
    localparam logic [29:0] W_PRESET = 30'h1FC2;
    localparam logic [29:0] W_COUNT  = 30'h1FC3;
    localparam logic [29:0] W_STATUS = 30'h1FC4;

    logic [29:0] word_addr;
    logic        ram_hit;
    logic        sel_led, sel_ctrl, sel_preset, sel_count, sel_status;
    logic        unused_addr_lo;

    logic [31:0] mem [DM_WORDS];

    logic [31:0] led_q,    led_d;
    logic [2:0]  ctrl_q,   ctrl_d;     // {irq_en, auto_reload, en}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q,  count_d;
    logic        expired_q, expired_d;
    logic        expire;

    // Byte-lane bits are ignored by every decode.
    assign unused_addr_lo = &{1'b0, bus.addr[1:0]};
    assign word_addr      = bus.addr[31:2];
    assign ram_hit        = (word_addr < 30'(DM_WORDS));
    assign sel_led        = (word_addr == W_LED);
    assign sel_ctrl       = (word_addr == W_CTRL);
    assign sel_preset     = (word_addr == W_PRESET);
    assign sel_count      = (word_addr == W_COUNT);
    assign sel_status     = (word_addr == W_STATUS);

    // RAM write port; contents survive reset, but a store during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus.we && ram_hit) begin
            mem[bus.addr[AW+1:2]] <= bus.wd;
        end
    end

    // Load mux: combinational in addr and current state, never in we.
    always_comb begin
        bus.rd = 32'd0;
        if (ram_hit) begin
            bus.rd = mem[bus.addr[AW+1:2]];
        end else if (sel_led) begin
            bus.rd = led_q;
        end else if (sel_ctrl) begin
            bus.rd = {29'd0, ctrl_q};
        end else if (sel_preset) begin
            bus.rd = preset_q;
        end else if (sel_count) begin
            bus.rd = count_q;
        end else if (sel_status) begin
            bus.rd = {31'd0, expired_q};
        end
    end

    // Next-state for registers and timer; a CPU COUNT write overrides the
    // whole timer step (no decrement, reload or expiry that cycle), and a new
    // expiry beats a same-cycle W1C of the flag.
    always_comb begin
        led_d     = led_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        expired_d = expired_q;
        expire    = 1'b0;

        if (bus.we && sel_count) begin
            count_d = bus.wd;
        end else if (ctrl_q[0] && (count_q != 32'd0)) begin
            if (count_q == 32'd1) begin
                expire  = 1'b1;
                count_d = ctrl_q[1] ? preset_q : 32'd0;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (bus.we && sel_led)    led_d    = bus.wd;
        if (bus.we && sel_ctrl)   ctrl_d   = bus.wd[2:0];
        if (bus.we && sel_preset) preset_d = bus.wd;
        if (bus.we && sel_status && bus.wd[0]) expired_d = 1'b0;
        if (expire) expired_d = 1'b1;
    end

    // Peripheral register bank with immediate asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= 32'd0;
            ctrl_q    <= 3'd0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign led = led_q[LED_W-1:0];
    assign irq = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: stimulus queues expected values, a monitor
// process samples the DUT and compares one line per check.
module tb_dmem_mmio;
    localparam logic [31:0] A_LED    = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = 32'h0000_7F04;
    localparam logic [31:0] A_PRESET = 32'h0000_7F08;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F0C;
    localparam logic [31:0] A_STATUS = 32'h0000_7F10;
    localparam int K_RD = 0, K_LED = 1, K_IRQ = 2;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        irq;

    dmem_mmio_if bus ();

    dmem_mmio #(.DM_WORDS(1024), .LED_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    event        push_ev;
    int          n_checks = 0;
    int          n_errors = 0;

    // Monitor: pops each queued expectation and samples the DUT output.
    initial begin
        forever begin
            @(push_ev);
            #1;
            while (exp_q.size() != 0) begin
                int          k;
                logic [31:0] e;
                logic [31:0] got;
                string       n;
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (k == K_RD)       got = bus.rd;
                else if (k == K_LED) got = {16'd0, led};
                else                 got = {31'd0, irq};
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %08h expected %08h", n, got, e);
                end else begin
                    $display("ok   %s: %08h", n, got);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        cyc();
        bus.we   = 1'b0;
    endtask

    task automatic chk(input int k, input logic [31:0] a, input logic [31:0] e, input string n);
        if (k == K_RD) bus.addr = a;
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
        ->push_ev;
        #2;
    endtask

    initial begin
        rst      = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'd0;
        bus.wd   = 32'd0;
        cyc();
        cyc();
        rst = 1'b0;
        chk(K_LED, 0, 32'd0, "reset_led");
        chk(K_IRQ, 0, 32'd0, "reset_irq");
        chk(K_RD, A_COUNT, 32'd0, "reset_count");
        chk(K_RD, A_CTRL, 32'd0, "reset_ctrl");

        // RAM round trip and unmapped window
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_1000, 32'h2222_2222);
        wr(32'h0000_7F14, 32'h1234_5678);
        chk(K_RD, 32'h0000_0010, 32'hDEAD_BEEF, "ram_rd_10");
        chk(K_RD, 32'h0000_0013, 32'hDEAD_BEEF, "ram_rd_13");
        chk(K_RD, 32'h0000_7F14, 32'd0, "unmapped_7f14");
        chk(K_RD, 32'h0000_0000, 32'h1111_1111, "ram_no_alias");
        cyc();
        chk(K_RD, 32'h0000_1000, 32'd0, "ram_end_unmapped");

        // LED and CTRL
        wr(A_LED, 32'h0001_A5A5);
        chk(K_LED, 0, 32'h0000_A5A5, "led_out");
        chk(K_RD, A_LED, 32'h0001_A5A5, "led_rd");
        wr(A_CTRL, 32'hFFFF_FFFF);
        chk(K_RD, A_CTRL, 32'h0000_0007, "ctrl_mask");
        chk(K_IRQ, 0, 32'd0, "irq_no_expiry");
        wr(A_CTRL, 32'd0);

        // One-shot timer
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h5);
        chk(K_RD, A_COUNT, 32'd3, "os_count_e1");
        cyc();
        chk(K_RD, A_COUNT, 32'd2, "os_count_e2");
        cyc();
        chk(K_RD, A_COUNT, 32'd1, "os_count_e3");
        chk(K_IRQ, 0, 32'd0, "os_irq_e3");
        cyc();
        chk(K_RD, A_COUNT, 32'd0, "os_count_e4");
        chk(K_IRQ, 0, 32'd1, "os_irq_e4");
        chk(K_RD, A_STATUS, 32'd1, "os_status_e4");
        cyc();
        chk(K_RD, A_COUNT, 32'd0, "os_count_hold");
        wr(A_STATUS, 32'd0);
        chk(K_IRQ, 0, 32'd1, "os_w0_noeffect");
        wr(A_STATUS, 32'd1);
        chk(K_IRQ, 0, 32'd0, "os_w1c_irq");
        chk(K_RD, A_STATUS, 32'd0, "os_w1c_status");

        // Auto-reload
        wr(A_CTRL, 32'd0);
        wr(A_PRESET, 32'd4);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h3);
        chk(K_RD, A_COUNT, 32'd2, "ar_a0");
        cyc();
        chk(K_RD, A_COUNT, 32'd1, "ar_a1");
        chk(K_RD, A_STATUS, 32'd0, "ar_a1_status");
        cyc();
        chk(K_RD, A_COUNT, 32'd4, "ar_a2_reload");
        chk(K_RD, A_STATUS, 32'd1, "ar_a2_status");
        wr(A_STATUS, 32'd1);
        chk(K_RD, A_STATUS, 32'd0, "ar_a3_cleared");
        chk(K_RD, A_COUNT, 32'd3, "ar_a3");
        cyc();
        cyc();
        chk(K_RD, A_COUNT, 32'd1, "ar_a5");
        wr(A_STATUS, 32'd1);
        chk(K_RD, A_STATUS, 32'd1, "ar_a6_set_wins");
        chk(K_RD, A_COUNT, 32'd4, "ar_a6_reload");
        cyc();
        cyc();
        cyc();
        cyc();
        chk(K_RD, A_COUNT, 32'd4, "ar_a10_reload");
        chk(K_RD, A_STATUS, 32'd1, "ar_a10_status");
        chk(K_IRQ, 0, 32'd0, "ar_irq_masked");
        cyc();
        cyc();
        cyc();
        wr(A_PRESET, 32'd9);
        chk(K_RD, A_COUNT, 32'd4, "ar_old_preset");
        chk(K_RD, A_PRESET, 32'd9, "ar_new_preset");
        cyc();
        chk(K_RD, A_COUNT, 32'd3, "ar_a15");

        // COUNT write collides with expiry
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h1);
        cyc();
        chk(K_RD, A_COUNT, 32'd1, "col_count_1");
        wr(A_COUNT, 32'd100);
        chk(K_RD, A_COUNT, 32'd100, "col_write_wins");
        chk(K_RD, A_STATUS, 32'd0, "col_no_expiry");
        cyc();
        chk(K_RD, A_COUNT, 32'd99, "col_resume");

        // Asynchronous reset mid-countdown
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        wr(A_LED, 32'd5);
        wr(A_PRESET, 32'd5);
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h7);
        cyc();
        chk(K_RD, A_COUNT, 32'd5, "rs_pre_count");
        chk(K_IRQ, 0, 32'd1, "rs_pre_irq");
        cyc();
        rst = 1'b1;
        chk(K_LED, 0, 32'd0, "rs_led");
        chk(K_IRQ, 0, 32'd0, "rs_irq");
        chk(K_RD, A_COUNT, 32'd0, "rs_count");
        chk(K_RD, A_CTRL, 32'd0, "rs_ctrl");
        bus.we   = 1'b1;
        bus.addr = A_LED;
        bus.wd   = 32'h0000_FFFF;
        cyc();
        bus.we = 1'b0;
        rst    = 1'b0;
        chk(K_LED, 0, 32'd0, "rs_store_dropped");
        chk(K_RD, 32'h0000_0010, 32'hDEAD_BEEF, "rs_ram_kept");
        cyc();
        cyc();
        chk(K_RD, A_COUNT, 32'd0, "rs_count_idle");
        chk(K_IRQ, 0, 32'd0, "rs_irq_idle");

        #10;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle CPU: it services every CPU load/store.
- Store: write strobe plus the byte address and data the ALU produces.
- Load: read data returned combinationally in the same cycle.

It contains a word-addressed data RAM plus a small memory-mapped peripheral window: an LED output register and a down-counting timer with auto-reload, sticky expiry flag and interrupt output. It sits between the CPU core and the board top level, next to instruction memory.

## Interface
Parameters:
- DM_WORDS, 1024, RAM depth in 32-bit words; DM_WORDS*4 must be ≤ 0x7F00.
- LED_W, 16, width of the LED output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  store strobe from the CPU (MemWrite).
- addr  in  32  byte address from the CPU ALU output; addr[1:0] ignored everywhere.
- wd  in  32  store data from the CPU.
- rd  out  32  load data to the CPU; combinational function of addr and current state.
- led  out  LED_W  equals LED[LED_W-1:0].
- irq  out  1  equals STATUS.expired & CTRL.irq_en.

## Operation
Address map (addr[1:0] dropped):
- RAM: addr < DM_WORDS*4. Index is addr[log2(DM_WORDS)+1:2]. Read and write.
- 0x7F00 LED: read/write, 32 bits stored.
- 0x7F04 CTRL: read/write. bit0 en, bit1 auto_reload, bit2 irq_en. Bits [31:3] read 0 and writes to them are ignored.
- 0x7F08 PRESET: read/write, 32 bits.
- 0x7F0C COUNT: read returns the live count; a write loads the count.
- 0x7F10 STATUS: bit0 expired (sticky). Writing 1 to bit0 clears it; writing 0 has no effect. Bits [31:1] read 0.
- Any other address is unmapped: reads return 0, writes are ignored.

Write and read behaviour:
- Writes occur on the rising edge when we=1.
- rd never depends on we. Read-during-write returns the old value; the new value is visible after the edge.

Timer rule, evaluated each edge from pre-edge register values:
- en=0, or COUNT=0: COUNT holds.
- en=1 and COUNT>1: COUNT ← COUNT−1.
- en=1 and COUNT=1: expired ← 1. COUNT ← PRESET if auto_reload=1, otherwise COUNT ← 0.
- Result: N edges from COUNT=N to expiry. With auto-reload the period is PRESET edges; PRESET=0 reloads 0 and the timer then halts.

Priority and boundary cases:
- A CPU write to COUNT in the same cycle as a decrement or reload: the write wins.
- A W1C of expired in the same cycle as a new expiry: the set wins, so expired stays 1.
- A write to CTRL in the expiry cycle: the expiry uses the old CTRL. The new CTRL applies from the next edge.
- A write to PRESET in the reload cycle: the reload uses the old PRESET.
- Counter arithmetic is unsigned 32-bit. No underflow is possible because COUNT=0 holds.

## Timing
- Loads have zero latency: rd is combinational.
- Stores and all timer updates take one edge.
- irq and led are pure functions of registers and carry no combinational path from the inputs.

Reset (asynchronous, effective immediately, mid-operation included):
- LED, CTRL, PRESET, COUNT and STATUS are cleared to 0, so led=0 and irq=0.
- RAM contents are not reset.
- An in-flight store coincident with rst is discarded.
- Counting resumes only after rst deasserts and software sets en.

## Test plan
- RAM round trip:
  - Store 0xDEADBEEF at 0x0000_0010, then load 0x10 → rd=0xDEADBEEF.
  - Load 0x13 → same data (low bits ignored).
  - Load 0x0000_7F14 → rd=0.
- LED register:
  - Store 0x0001_A5A5 to 0x7F00 → led=0xA5A5 after the edge, and rd at 0x7F00 reads 0x0001_A5A5.
  - Store to 0x7F04 with wd=0xFFFF_FFFF → CTRL reads 0x7.
- One-shot timer:
  - Store COUNT=3, then CTRL=0x5 → COUNT reads 2, 1, 0 on successive edges.
  - expired=1 and irq=1 on the third edge after CTRL is written; COUNT then holds 0.
  - Store 1 to STATUS → irq=0.
- Auto-reload:
  - Store PRESET=4, COUNT=2, then CTRL=0x3 → expiries on edges 2, 6, 10 after the CTRL write, with COUNT reloading to 4 each time.
  - Collision: issue a W1C on expiry edge 6 → expired remains 1.
- Write collision:
  - With en=1, write COUNT=100 in the cycle where COUNT=1 → COUNT=100 and expired stays 0.
- Asynchronous reset:
  - Assert rst mid-countdown with irq=1 → led, irq, COUNT and CTRL go to 0 before the next clk edge.
  - Previously written RAM word is still readable after rst deasserts.
